// File: rtl/shifter_arbiter_if.sv
// Bundle of the two requester handshakes, their response channels and the external shifter hookup.
// The slave modport is the arbiter side; the master modport is the requester/shifter side.
interface shifter_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_in;
  logic [3:0]  req0_cnt;
  logic [1:0]  req0_op;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [15:0] rsp0_out;

  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_in;
  logic [3:0]  req1_cnt;
  logic [1:0]  req1_op;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [15:0] rsp1_out;

  logic [15:0] sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [15:0] sh_out;

  modport slave (
    input  req0_valid, req0_in, req0_cnt, req0_op, rsp0_ready,
    input  req1_valid, req1_in, req1_cnt, req1_op, rsp1_ready,
    input  sh_out,
    output req0_ready, rsp0_valid, rsp0_out,
    output req1_ready, rsp1_valid, rsp1_out,
    output sh_in, sh_cnt, sh_op
  );

  modport master (
    output req0_valid, req0_in, req0_cnt, req0_op, rsp0_ready,
    output req1_valid, req1_in, req1_cnt, req1_op, rsp1_ready,
    output sh_out,
    input  req0_ready, rsp0_valid, rsp0_out,
    input  req1_ready, rsp1_valid, rsp1_out,
    input  sh_in, sh_cnt, sh_op
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Shares one external combinational 16-bit shifter between two requesters, one operation in flight.
// The shifter result is captured on the accept edge and held until its owner takes it.
module shifter_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input logic              clk,
  input logic              rst,
  shifter_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RESP} state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_lastGrant;
  logic [15:0] r_result;

  logic        w_grant;
  logic        w_winner;
  logic        w_rspTaken;
  logic        w_rsp0Active;
  logic        w_rsp1Active;

  // A grant exists only in IDLE and is held off while reset is asserted
  always_comb begin
    w_grant  = 1'b0;
    w_winner = 1'b0;
    if (r_state == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant  = 1'b1;
        w_winner = FAIR ? ~r_lastGrant : 1'b0;
      end else if (bus.req0_valid) begin
        w_grant  = 1'b1;
        w_winner = 1'b0;
      end else if (bus.req1_valid) begin
        w_grant  = 1'b1;
        w_winner = 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_grant & ~w_winner;
  assign bus.req1_ready = w_grant &  w_winner;

  assign bus.sh_in  = w_grant ? (w_winner ? bus.req1_in  : bus.req0_in)  : '0;
  assign bus.sh_cnt = w_grant ? (w_winner ? bus.req1_cnt : bus.req0_cnt) : '0;
  assign bus.sh_op  = w_grant ? (w_winner ? bus.req1_op  : bus.req0_op)  : '0;

  assign w_rsp0Active = (r_state == RESP) && !r_owner;
  assign w_rsp1Active = (r_state == RESP) &&  r_owner;

  assign bus.rsp0_valid = w_rsp0Active;
  assign bus.rsp1_valid = w_rsp1Active;
  assign bus.rsp0_out   = w_rsp0Active ? r_result : '0;
  assign bus.rsp1_out   = w_rsp1Active ? r_result : '0;

  // Only the owner's rsp_ready can retire the held result
  assign w_rspTaken = r_owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_lastGrant <= 1'b1;
      r_result    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_result    <= bus.sh_out;
            r_owner     <= w_winner;
            r_lastGrant <= w_winner;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (w_rspTaken) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
